// File: rtl/lane_judge.sv
// Single-lane rhythm-game judge: walks a chart of tap/hold entries and grades
// key presses against song time, producing registered judgment pulses and a combo count.
module lane_judge #(
  parameter int NUM_NOTES   = 148,
  parameter int PERFECT_WIN = 3,
  parameter int GOOD_WIN    = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [13:0] song_time,
  input  logic        key_down,
  input  logic [15:0] key_1,
  input  logic [15:0] key_2,
  output logic [7:0]  addr,
  output logic        perfect,
  output logic        good,
  output logic        miss,
  output logic        hold_ok,
  output logic        hold_active,
  output logic [9:0]  combo,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    PLAYING,
    HOLDING,
    DONE
  } state_t;

  localparam logic signed [14:0] GOOD_HI    = 15'(GOOD_WIN);
  localparam logic signed [14:0] GOOD_LO    = -GOOD_HI;
  localparam logic signed [14:0] PERFECT_HI = 15'(PERFECT_WIN);
  localparam logic signed [14:0] PERFECT_LO = -PERFECT_HI;
  localparam logic [7:0]         LAST_ADDR  = 8'(NUM_NOTES);
  localparam logic [9:0]         COMBO_MAX  = '1;

  state_t      r_state;
  logic [7:0]  r_addr;
  logic [9:0]  r_combo;
  logic        r_key_prev;
  logic        r_perfect;
  logic        r_good;
  logic        r_miss;
  logic        r_hold_ok;

  state_t      w_next_state;
  logic [7:0]  w_next_addr;
  logic [9:0]  w_next_combo;
  logic        w_perfect;
  logic        w_good;
  logic        w_miss;
  logic        w_hold_ok;

  logic [13:0]        w_note_time;
  logic signed [14:0] w_diff;
  logic signed [14:0] w_end_lead;
  logic               w_press;
  logic               w_release;
  logic               w_in_good;
  logic               w_in_perfect;
  logic               w_late;
  logic               w_is_hold_start;
  logic               w_chart_end;
  logic [9:0]         w_combo_inc;
  logic               w_unused_key2;

  // Widened to 15 bits so early notes (note_time < GOOD_WIN) never underflow.
  assign w_note_time     = key_1[13:0];
  assign w_diff          = signed'({1'b0, song_time}) - signed'({1'b0, w_note_time});
  assign w_end_lead      = signed'({1'b0, w_note_time}) - signed'({1'b0, song_time});
  assign w_press         = key_down & ~r_key_prev;
  assign w_release       = ~key_down & r_key_prev;
  assign w_in_good       = (w_diff <= GOOD_HI) && (w_diff >= GOOD_LO);
  assign w_in_perfect    = (w_diff <= PERFECT_HI) && (w_diff >= PERFECT_LO);
  assign w_late          = (w_diff > GOOD_HI);
  assign w_is_hold_start = (key_1[15:14] == 2'b01);
  assign w_chart_end     = (r_addr >= LAST_ADDR);
  assign w_combo_inc     = (r_combo == COMBO_MAX) ? r_combo : r_combo + 10'd1;

  // The look-ahead entry is part of the chart port pair but judging only needs key_1.
  assign w_unused_key2 = ^key_2;

  always_comb begin
    w_next_state = r_state;
    w_next_addr  = r_addr;
    w_next_combo = r_combo;
    w_perfect    = 1'b0;
    w_good       = 1'b0;
    w_miss       = 1'b0;
    w_hold_ok    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = PLAYING;
          w_next_addr  = 8'd0;
          w_next_combo = 10'd0;
        end
      end
      PLAYING: begin
        if (w_chart_end) begin
          w_next_state = DONE;
        end else if (w_press && w_in_good) begin
          w_perfect    = w_in_perfect;
          w_good       = ~w_in_perfect;
          w_next_combo = w_combo_inc;
          w_next_addr  = r_addr + 8'd1;
          if (w_is_hold_start) begin
            w_next_state = HOLDING;
          end
        end else if (w_late) begin
          // A missed hold-start also skips its hold-end entry.
          w_miss       = 1'b1;
          w_next_combo = 10'd0;
          w_next_addr  = r_addr + (w_is_hold_start ? 8'd2 : 8'd1);
        end
      end
      HOLDING: begin
        if (key_down && (w_end_lead <= 15'sd0)) begin
          w_hold_ok    = 1'b1;
          w_next_combo = w_combo_inc;
          w_next_addr  = r_addr + 8'd1;
          w_next_state = PLAYING;
        end else if (w_release) begin
          if (w_end_lead <= GOOD_HI) begin
            w_hold_ok    = 1'b1;
            w_next_combo = w_combo_inc;
          end else begin
            w_miss       = 1'b1;
            w_next_combo = 10'd0;
          end
          w_next_addr  = r_addr + 8'd1;
          w_next_state = PLAYING;
        end
      end
      DONE: begin
        w_next_state = DONE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_addr     <= 8'd0;
      r_combo    <= 10'd0;
      r_key_prev <= 1'b0;
      r_perfect  <= 1'b0;
      r_good     <= 1'b0;
      r_miss     <= 1'b0;
      r_hold_ok  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_addr     <= w_next_addr;
      r_combo    <= w_next_combo;
      r_key_prev <= key_down;
      r_perfect  <= w_perfect;
      r_good     <= w_good;
      r_miss     <= w_miss;
      r_hold_ok  <= w_hold_ok;
    end
  end

  assign addr        = r_addr;
  assign combo       = r_combo;
  assign perfect     = r_perfect;
  assign good        = r_good;
  assign miss        = r_miss;
  assign hold_ok     = r_hold_ok;
  assign hold_active = (r_state == HOLDING);
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_lane_judge.sv
// Directed bench for lane_judge: a 4-entry chart memory addressed by the DUT,
// with one task per scenario comparing all outputs against hand-computed vectors.
module tb_lane_judge;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [13:0] song_time = 14'd0;
  logic        key_down = 1'b0;
  logic [15:0] key_1;
  logic [15:0] key_2;
  logic [7:0]  addr;
  logic        perfect;
  logic        good;
  logic        miss;
  logic        hold_ok;
  logic        hold_active;
  logic [9:0]  combo;
  logic        done;

  logic [15:0] chart [0:3];
  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 Clk = ~Clk;

  assign key_1 = chart[addr[1:0]];
  assign key_2 = chart[addr[1:0] + 2'd1];

  lane_judge #(
    .NUM_NOTES  (2),
    .PERFECT_WIN(3),
    .GOOD_WIN   (6)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .song_time  (song_time),
    .key_down   (key_down),
    .key_1      (key_1),
    .key_2      (key_2),
    .addr       (addr),
    .perfect    (perfect),
    .good       (good),
    .miss       (miss),
    .hold_ok    (hold_ok),
    .hold_active(hold_active),
    .combo      (combo),
    .done       (done)
  );

  // Output vector layout: perfect, good, miss, hold_ok, hold_active, done, addr[7:0], combo[9:0].
  function automatic logic [23:0] snap();
    return {perfect, good, miss, hold_ok, hold_active, done, addr, combo};
  endfunction

  function automatic logic [23:0] ev(input bit p, input bit g, input bit m, input bit h,
                                     input bit ha, input bit d, input int a, input int c);
    return {p, g, m, h, ha, d, 8'(a), 10'(c)};
  endfunction

  function automatic string fmt(input logic [23:0] v);
    return $sformatf("perfect=%b good=%b miss=%b hold_ok=%b hold_active=%b done=%b addr=%0d combo=%0d",
                     v[23], v[22], v[21], v[20], v[19], v[18], v[17:10], v[9:0]);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    start    = 1'b0;
    key_down = 1'b0;
    tick();
    Reset    = 1'b0;
  endtask

  task automatic begin_chart(input logic [13:0] t0);
    do_reset();
    song_time = t0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    chart[0] = 16'h0032; chart[1] = 16'h0064; chart[2] = 16'h0000; chart[3] = 16'h0000;
    Reset = 1'b1; start = 1'b1; song_time = 14'd50; key_down = 1'b0;
    tick();
    e = ev(0,0,0,0,0,0,0,0);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL reset_with_start: got %s, expected %s", fmt(snap()), fmt(e));
    end
    Reset = 1'b0; start = 1'b0;
    tick();
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL reset_idle: got %s, expected %s", fmt(snap()), fmt(e));
    end
    key_down = 1'b1;
    tick();
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL idle_press_ignored: got %s, expected %s", fmt(snap()), fmt(e));
    end
    key_down = 1'b0;
  endtask

  typedef struct {
    int t;
    bit p;
    bit g;
  } hit_vec_t;

  // Tap @50 with perfect window 3 and good window 6.
  task automatic test_hit_windows();
    hit_vec_t vecs [9];
    logic [23:0] e;
    int a;
    vecs[0] = '{51, 1, 0};
    vecs[1] = '{53, 1, 0};
    vecs[2] = '{54, 0, 1};
    vecs[3] = '{55, 0, 1};
    vecs[4] = '{56, 0, 1};
    vecs[5] = '{47, 1, 0};
    vecs[6] = '{46, 0, 1};
    vecs[7] = '{44, 0, 1};
    vecs[8] = '{43, 0, 0};
    chart[0] = 16'h0032; chart[1] = 16'h0064;
    foreach (vecs[i]) begin
      begin_chart(14'd30);
      song_time = 14'(vecs[i].t);
      key_down  = 1'b1;
      tick();
      a = (vecs[i].p || vecs[i].g) ? 1 : 0;
      e = ev(vecs[i].p, vecs[i].g, 0, 0, 0, 0, a, a);
      n_compared++;
      if (snap() !== e) begin
        n_mismatched++;
        $display("[TB] FAIL hit_window@%0d: got %s, expected %s", vecs[i].t, fmt(snap()), fmt(e));
      end
      key_down = 1'b0;
      tick();
      e = ev(0, 0, 0, 0, 0, 0, a, a);
      n_compared++;
      if (snap() !== e) begin
        n_mismatched++;
        $display("[TB] FAIL hit_pulse_clear@%0d: got %s, expected %s", vecs[i].t, fmt(snap()), fmt(e));
      end
    end
    begin_chart(14'd30);
    song_time = 14'd40;
    key_down  = 1'b1;
    tick();
    e = ev(0,0,0,0,0,0,0,0);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL early_press@40: got %s, expected %s", fmt(snap()), fmt(e));
    end
    key_down = 1'b0;
  endtask

  task automatic test_tap_miss();
    logic [23:0] e;
    chart[0] = 16'h0014; chart[1] = 16'h0032;
    begin_chart(14'd18);
    song_time = 14'd20; key_down = 1'b1;
    tick();
    e = ev(1,0,0,0,0,0,1,1);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL miss_setup_hit: got %s, expected %s", fmt(snap()), fmt(e));
    end
    key_down = 1'b0;
    tick();
    for (int t = 50; t <= 57; t++) begin
      song_time = 14'(t);
      tick();
      e = (t < 57) ? ev(0,0,0,0,0,0,1,1) : ev(0,0,1,0,0,0,2,0);
      n_compared++;
      if (snap() !== e) begin
        n_mismatched++;
        $display("[TB] FAIL tap_miss@%0d: got %s, expected %s", t, fmt(snap()), fmt(e));
      end
    end
    tick();
    e = ev(0,0,0,0,0,1,2,0);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL miss_then_done: got %s, expected %s", fmt(snap()), fmt(e));
    end
  endtask

  task automatic test_hold_complete();
    logic [23:0] e;
    chart[0] = 16'h411A; chart[1] = 16'h8143; chart[2] = 16'h0000;
    begin_chart(14'd270);
    song_time = 14'd282; key_down = 1'b1;
    tick();
    e = ev(1,0,0,0,1,0,1,1);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL hold_start_hit: got %s, expected %s", fmt(snap()), fmt(e));
    end
    for (int t = 283; t <= 322; t++) begin
      song_time = 14'(t);
      tick();
      e = ev(0,0,0,0,1,0,1,1);
      n_compared++;
      if (snap() !== e) begin
        n_mismatched++;
        $display("[TB] FAIL holding@%0d: got %s, expected %s", t, fmt(snap()), fmt(e));
      end
    end
    song_time = 14'd323;
    tick();
    e = ev(0,0,0,1,0,0,2,2);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL hold_complete: got %s, expected %s", fmt(snap()), fmt(e));
    end
    key_down = 1'b0;
    tick();
    e = ev(0,0,0,0,0,1,2,2);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL hold_then_done: got %s, expected %s", fmt(snap()), fmt(e));
    end
  endtask

  // Hold @282 ending @323: release within 6 frames of the end completes the hold.
  task automatic test_hold_release();
    int rel [3];
    logic [23:0] e;
    rel[0] = 300; rel[1] = 316; rel[2] = 317;
    chart[0] = 16'h411A; chart[1] = 16'h8143;
    foreach (rel[i]) begin
      begin_chart(14'd270);
      song_time = 14'd282; key_down = 1'b1;
      tick();
      song_time = 14'(rel[i]); key_down = 1'b0;
      tick();
      e = (rel[i] >= 317) ? ev(0,0,0,1,0,0,2,2) : ev(0,0,1,0,0,0,2,0);
      n_compared++;
      if (snap() !== e) begin
        n_mismatched++;
        $display("[TB] FAIL hold_release@%0d: got %s, expected %s", rel[i], fmt(snap()), fmt(e));
      end
    end
  endtask

  task automatic test_hold_start_miss();
    logic [23:0] e;
    chart[0] = 16'h411A; chart[1] = 16'h8143;
    begin_chart(14'd280);
    song_time = 14'd288;
    tick();
    e = ev(0,0,0,0,0,0,0,0);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL hold_start_edge@288: got %s, expected %s", fmt(snap()), fmt(e));
    end
    song_time = 14'd289;
    tick();
    e = ev(0,0,1,0,0,0,2,0);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL hold_start_miss@289: got %s, expected %s", fmt(snap()), fmt(e));
    end
  endtask

  task automatic test_mid_hold_reset();
    logic [23:0] e;
    chart[0] = 16'h411A; chart[1] = 16'h8143;
    begin_chart(14'd270);
    song_time = 14'd282; key_down = 1'b1;
    tick();
    song_time = 14'd300;
    tick();
    e = ev(0,0,0,0,1,0,1,1);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL mid_hold_pre_reset: got %s, expected %s", fmt(snap()), fmt(e));
    end
    Reset = 1'b1; start = 1'b1;
    tick();
    e = ev(0,0,0,0,0,0,0,0);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL mid_hold_reset: got %s, expected %s", fmt(snap()), fmt(e));
    end
    Reset = 1'b0; start = 1'b0; key_down = 1'b0;
    tick();
    key_down = 1'b1;
    tick();
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_idle_press: got %s, expected %s", fmt(snap()), fmt(e));
    end
    key_down = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [23:0] e;
    chart[0] = 16'h0014; chart[1] = 16'h001E; chart[2] = 16'h0028; chart[3] = 16'h0000;
    begin_chart(14'd15);
    song_time = 14'd20; key_down = 1'b1;
    tick();
    e = ev(1,0,0,0,0,0,1,1);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_first_hit: got %s, expected %s", fmt(snap()), fmt(e));
    end
    key_down = 1'b0;
    tick();
    song_time = 14'd30; key_down = 1'b1;
    tick();
    e = ev(1,0,0,0,0,0,2,2);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_second_hit: got %s, expected %s", fmt(snap()), fmt(e));
    end
    key_down = 1'b0;
    tick();
    e = ev(0,0,0,0,0,1,2,2);
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL chart_done: got %s, expected %s", fmt(snap()), fmt(e));
    end
    song_time = 14'd40; key_down = 1'b1;
    tick();
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL done_press_ignored: got %s, expected %s", fmt(snap()), fmt(e));
    end
    key_down = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL done_start_ignored: got %s, expected %s", fmt(snap()), fmt(e));
    end
    song_time = 14'd200;
    tick();
    n_compared++;
    if (snap() !== e) begin
      n_mismatched++;
      $display("[TB] FAIL done_no_miss: got %s, expected %s", fmt(snap()), fmt(e));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    chart[0] = 16'h0000; chart[1] = 16'h0000; chart[2] = 16'h0000; chart[3] = 16'h0000;
    test_reset();
    test_hit_windows();
    test_tap_miss();
    test_hold_complete();
    test_hold_release();
    test_hold_start_miss();
    test_mid_hold_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/lane_judge.md
LANE_JUDGE -- requirements
Module: lane_judge

Interface
REQ-001 SHALL have parameter NUM_NOTES, default 148: number of valid chart entries; the end-of-chart address.
REQ-002 SHALL have parameter PERFECT_WIN, default 3: perfect half-window, in frames.
REQ-003 SHALL have parameter GOOD_WIN, default 6: good half-window, in frames, with GOOD_WIN > PERFECT_WIN.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins the chart.
REQ-007 SHALL have port song_time, input, 14 bits: current song time in 1/60 s frames, monotonic non-decreasing.
REQ-008 SHALL have port key_down, input, 1 bit: lane key level, already synchronized.
REQ-009 SHALL have port key_1, input, 16 bits: chart entry at addr.
REQ-010 SHALL have port key_2, input, 16 bits: chart entry at addr+1.
REQ-011 SHALL have port addr, output, 8 bits: chart read pointer.
REQ-012 SHALL have port perfect, output, 1 bit: one-cycle judgment pulse.
REQ-013 SHALL have port good, output, 1 bit: one-cycle judgment pulse.
REQ-014 SHALL have port miss, output, 1 bit: one-cycle judgment pulse.
REQ-015 SHALL have port hold_ok, output, 1 bit: one-cycle pulse when a hold completes.
REQ-016 SHALL have port hold_active, output, 1 bit: high while in HOLDING.
REQ-017 SHALL have port combo, output, 10 bits: current consecutive-hit count.
REQ-018 SHALL have port done, output, 1 bit: high in DONE.

Function
REQ-019 SHALL decode entry fields as follows: [15:14] type (00 tap, 01 hold-start, 10 hold-end, 11 treated as tap); [13:0] note_time in frames.
REQ-020 SHALL compute diff = song_time - note_time(key_1) as a 15-bit signed value, so that no underflow occurs when note_time < GOOD_WIN.
REQ-021 SHALL implement the states IDLE, PLAYING, HOLDING and DONE.
REQ-022 SHALL transition IDLE -> PLAYING on start, setting addr=0 and combo=0; start SHALL be ignored in every other state.
REQ-023 SHALL register key_down into key_prev; a press edge is key_down & ~key_prev, and every edge is consumed in the cycle it occurs.
REQ-024 SHALL register all outputs; a judgment caused by conditions in cycle N SHALL appear as a pulse, and as the addr/combo update, in cycle N+1.
REQ-025 SHALL judge in PLAYING only on a press edge with |diff| <= GOOD_WIN:
- |diff| <= PERFECT_WIN -> perfect; otherwise -> good.
- combo += 1, saturating at 1023.
REQ-026 SHALL ignore a press edge with diff < -GOOD_WIN (early press), with no pulse and no addr change.
REQ-027 SHALL, in PLAYING with no qualifying hit and diff > GOOD_WIN, pulse miss and clear combo to 0.
REQ-028 SHALL make hit and expiry mutually exclusive by window definition, so at most one judgment pulse occurs per cycle.
REQ-029 SHALL, on a tap or type-11 hit or miss, set addr += 1.
REQ-030 SHALL, on a hold-start hit, set addr += 1 (now pointing at the hold-end) and go to HOLDING.
REQ-031 SHALL, on a hold-start miss, set addr += 2 (skipping the hold-end) and remain in PLAYING.
REQ-032 SHALL, in HOLDING, use the hold-end time from key_1:
- song_time >= end_time with key_down high, or a release with end_time - song_time <= GOOD_WIN -> hold_ok, combo += 1 (saturating), addr += 1, go to PLAYING.
- release earlier than that -> miss, combo = 0, addr += 1, go to PLAYING.
REQ-033 SHALL ignore press edges while in HOLDING.
REQ-034 SHALL enter DONE from PLAYING when addr == NUM_NOTES; addr SHALL hold, no pulses SHALL occur, and DONE SHALL hold until Reset.
REQ-035 SHALL drive hold_active = (state == HOLDING) and done = (state == DONE) from registered state.
REQ-036 SHALL widen the addr increment to 8 bits so that addr + 2 at NUM_NOTES - 1 goes to DONE without wrapping.

Reset
REQ-037 SHALL, on Reset high at a Clk edge, clear in all states (including mid-hold): state = IDLE, addr = 0, combo = 0, key_prev = 0, all pulse outputs = 0, hold_active = 0, done = 0.
REQ-038 SHALL give Reset priority over start and over all judgments in the same cycle.

Verification
REQ-039 SHALL be verified by a tap-perfect scenario: key_1 = 0x0032 (tap @50), press at song_time 51 -> perfect pulse, addr 0->1, combo 1.
REQ-040 SHALL be verified by tap-good and early-press scenarios: press at 55 -> good; press at 40 -> no pulse, addr unchanged.
REQ-041 SHALL be verified by a tap-miss scenario: no press, song_time stepped 50..57 -> miss exactly one cycle after song_time = 57, combo 0.
REQ-042 SHALL be verified by a hold-complete scenario: key_1 = 0x411A (hold @282), key_2 = 0x8143 (end @323); press at 282, hold through 323 -> perfect, hold_active, hold_ok, addr += 2, combo += 2.
REQ-043 SHALL be verified by hold-break and mid-hold reset scenarios:
- same hold, release at 300 -> miss, combo 0, addr += 2.
- Reset asserted at 300 -> IDLE, addr 0, hold_active 0.
REQ-044 SHALL be verified by an end-of-chart scenario: NUM_NOTES = 2, two taps hit -> done high; later press edges and start ignored.
